// File: rtl/shannon_whitaker_pkg.sv
// Shared constants for the Shannon-Whitaker half-band filter family
// (2x interpolator and lowpass filter).
//   - NTAPS      : number of symmetric coefficient pairs
//   - COEFW      : coefficient width (signed)
//   - Q_SHIFT    : fractional bits of the coefficients (Q14)
//   - RND_CONST  : round-half-up constant added before the Q14 shift
//   - LAT        : input-beat to output-beat latency in clocks
//   - coef(k)    : tap k, k=0 is the tap nearest the centre
package shannon_whitaker_pkg;

    localparam int unsigned NTAPS     = 8;
    localparam int unsigned COEFW     = 16;
    localparam int unsigned Q_SHIFT   = 14;
    localparam int          RND_CONST = 1 << (Q_SHIFT - 1);
    localparam int unsigned LAT       = 6;

    typedef logic signed [COEFW-1:0] coef_t;

    function automatic coef_t coef(input int unsigned k);
        coef_t c;
        case (k)
            0:       c =  16'sd10342;
            1:       c = -16'sd3216;
            2:       c =  16'sd1672;
            3:       c = -16'sd949;
            4:       c =  16'sd526;
            5:       c = -16'sd263;
            6:       c =  16'sd105;
            7:       c =  16'sd23;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/shannon_whitaker_fourtap.sv
// fourtap_systolic_preadd: four symmetric taps of a pre-add FIR.
//   o_pcout = sum_k coef[k]*(a[k]+b[k]) + pcin, fully registered.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_a, i_b       : four sample pairs to pre-add (signed, DW bits)
//   i_coef         : four signed coefficients
//   i_pcin         : partial sum from the upstream instance (tie to 0 if none)
//   o_pcout        : registered partial sum
// Latency from i_a/i_b: 3 clocks with CASCADE="FALSE", 4 with "TRUE".
// i_pcin is consumed at the final add, so the upstream instance (3-clock
// latency, fed the same clock) lines up with the extra skew stage here.
module fourtap_systolic_preadd
    import shannon_whitaker_pkg::*;
#(
    parameter int    DW      = 12,
    parameter int    AW      = 32,
    parameter string CASCADE = "FALSE"
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [3:0][DW-1:0]     i_a,
    input  logic [3:0][DW-1:0]     i_b,
    input  logic [3:0][COEFW-1:0]  i_coef,
    input  logic signed [AW-1:0]   i_pcin,
    output logic signed [AW-1:0]   o_pcout
);

    localparam bit USE_SKEW = (CASCADE == "TRUE");
    localparam int PW       = DW + 1;

    logic [3:0][DW-1:0]  w_a;
    logic [3:0][DW-1:0]  w_b;
    logic signed [PW-1:0] r_pre  [4];
    logic signed [AW-1:0] r_prod [4];

    // Cascaded instance delays its data one clock to meet the upstream sum.
    if (USE_SKEW) begin : g_skew
        logic [3:0][DW-1:0] r_a;
        logic [3:0][DW-1:0] r_b;
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_a <= '0;
                r_b <= '0;
            end else begin
                r_a <= i_a;
                r_b <= i_b;
            end
        end
        assign w_a = r_a;
        assign w_b = r_b;
    end else begin : g_noskew
        assign w_a = i_a;
        assign w_b = i_b;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned k = 0; k < 4; k++) begin
                r_pre[k]  <= '0;
                r_prod[k] <= '0;
            end
            o_pcout <= '0;
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                r_pre[k]  <= PW'($signed(w_a[k])) + PW'($signed(w_b[k]));
                r_prod[k] <= AW'(r_pre[k]) * AW'($signed(i_coef[k]));
            end
            o_pcout <= r_prod[0] + r_prod[1] + r_prod[2] + r_prod[3] + i_pcin;
        end
    end

endmodule

// File: rtl/shannon_whitaker_interp2x.sv
// 2x half-band interpolator, 4 samples in / 8 samples out per clock.
//   even outputs y[2n]   = x[n-8]
//   odd  outputs y[2n+1] = round_half_up(sum C[k]*(x[n-8-k]+x[n-7+k]) / 2^14)
// Odd and even results saturate to OUTBITS.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   dat_i   : input beat, dat_i[k] = x[4b+k]
//   valid_i : beat qualifier; invalid beats enter the history as zeros
//   dat_o   : output beat, dat_o[k] = y[8b+k], LAT clocks after input beat b
//   valid_o : valid_i delayed by LAT clocks
module shannon_whitaker_interp2x
    import shannon_whitaker_pkg::*;
#(
    parameter int INBITS  = 12,
    parameter int OUTBITS = 12
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [3:0][INBITS-1:0]   dat_i,
    input  logic                     valid_i,
    output logic [7:0][OUTBITS-1:0]  dat_o,
    output logic                     valid_o
);

    // 19 newest samples: r_hist[i] = x[4b+3-i] one clock after beat b.
    localparam int unsigned HIST = 19;
    localparam int unsigned EDLY = 4;
    localparam int ACCW = (INBITS + 20 > OUTBITS + 2) ? INBITS + 20 : OUTBITS + 2;
    localparam int EW   = ((INBITS > OUTBITS) ? INBITS : OUTBITS) + 1;

    localparam logic signed [ACCW-1:0] OMAX = ACCW'(2 ** (OUTBITS - 1) - 1);
    localparam logic signed [ACCW-1:0] OMIN = -OMAX - ACCW'(1);
    localparam logic signed [EW-1:0]   EMAX = EW'(2 ** (OUTBITS - 1) - 1);
    localparam logic signed [EW-1:0]   EMIN = -EMAX - EW'(1);

    logic [INBITS-1:0]         r_hist [HIST];
    logic [3:0][INBITS-1:0]    r_even [EDLY];
    logic [LAT-1:0]            r_vld;
    logic [3:0][COEFW-1:0]     w_coef_lo;
    logic [3:0][COEFW-1:0]     w_coef_hi;
    logic [3:0][OUTBITS-1:0]   w_odd;
    logic [3:0][OUTBITS-1:0]   w_even;
    logic signed [EW-1:0]      w_ext;

    // Sample history, invalid beats replaced by zeros.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < HIST; i++) begin
                r_hist[i] <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < 4; j++) begin
                r_hist[3-j] <= valid_i ? dat_i[j] : '0;
            end
            for (int unsigned i = 4; i < HIST; i++) begin
                r_hist[i] <= r_hist[i-4];
            end
        end
    end

    always_comb begin
        w_coef_lo = '0;
        w_coef_hi = '0;
        for (int unsigned k = 0; k < NTAPS / 2; k++) begin
            w_coef_lo[k] = coef(k);
            w_coef_hi[k] = coef(k + NTAPS / 2);
        end
    end

    // Odd lane m computes y[2n+1] with n = 4b+m. Taps 0..3 in the first
    // instance, taps 4..7 in the cascaded one.
    for (genvar m = 0; m < 4; m++) begin : g_odd
        logic [3:0][INBITS-1:0]  w_a_lo;
        logic [3:0][INBITS-1:0]  w_b_lo;
        logic [3:0][INBITS-1:0]  w_a_hi;
        logic [3:0][INBITS-1:0]  w_b_hi;
        logic signed [ACCW-1:0]  w_pc_lo;
        logic signed [ACCW-1:0]  w_sum;
        logic signed [ACCW-1:0]  w_rnd;
        logic [OUTBITS-1:0]      w_sat;

        for (genvar k = 0; k < 4; k++) begin : g_tap
            assign w_a_lo[k] = r_hist[11 - m + k];
            assign w_b_lo[k] = r_hist[10 - m - k];
            assign w_a_hi[k] = r_hist[15 - m + k];
            assign w_b_hi[k] = r_hist[6 - m - k];
        end

        fourtap_systolic_preadd #(
            .DW      (INBITS),
            .AW      (ACCW),
            .CASCADE ("FALSE")
        ) u_mac_lo (
            .i_clk   (clk_i),
            .i_rst_n (rst_ni),
            .i_a     (w_a_lo),
            .i_b     (w_b_lo),
            .i_coef  (w_coef_lo),
            .i_pcin  ('0),
            .o_pcout (w_pc_lo)
        );

        fourtap_systolic_preadd #(
            .DW      (INBITS),
            .AW      (ACCW),
            .CASCADE ("TRUE")
        ) u_mac_hi (
            .i_clk   (clk_i),
            .i_rst_n (rst_ni),
            .i_a     (w_a_hi),
            .i_b     (w_b_hi),
            .i_coef  (w_coef_hi),
            .i_pcin  (w_pc_lo),
            .o_pcout (w_sum)
        );

        always_comb begin
            w_rnd = (w_sum + ACCW'(RND_CONST)) >>> Q_SHIFT;
            if (w_rnd > OMAX) begin
                w_sat = OMAX[OUTBITS-1:0];
            end else if (w_rnd < OMIN) begin
                w_sat = OMIN[OUTBITS-1:0];
            end else begin
                w_sat = w_rnd[OUTBITS-1:0];
            end
        end

        assign w_odd[m] = w_sat;
    end

    // Even lanes: x[4b+m-8] sits at r_hist[11-m]; delay to match the MAC path.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned s = 0; s < EDLY; s++) begin
                r_even[s] <= '0;
            end
        end else begin
            for (int unsigned m = 0; m < 4; m++) begin
                r_even[0][m] <= r_hist[11-m];
            end
            for (int unsigned s = 1; s < EDLY; s++) begin
                r_even[s] <= r_even[s-1];
            end
        end
    end

    always_comb begin
        w_even = '0;
        w_ext  = '0;
        for (int unsigned m = 0; m < 4; m++) begin
            w_ext = EW'($signed(r_even[EDLY-1][m]));
            if (w_ext > EMAX) begin
                w_even[m] = EMAX[OUTBITS-1:0];
            end else if (w_ext < EMIN) begin
                w_even[m] = EMIN[OUTBITS-1:0];
            end else begin
                w_even[m] = w_ext[OUTBITS-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dat_o <= '0;
            r_vld <= '0;
        end else begin
            for (int unsigned m = 0; m < 4; m++) begin
                dat_o[2*m]   <= w_even[m];
                dat_o[2*m+1] <= w_odd[m];
            end
            r_vld <= {r_vld[LAT-2:0], valid_i};
        end
    end

    assign valid_o = r_vld[LAT-1];

endmodule

// File: tb/tb_shannon_whitaker_interp2x.sv
// Self-checking bench for shannon_whitaker_interp2x: scoreboard against a
// direct formula model plus table-driven steady-state vectors and
// hand-written impulse / sign-pattern / valid-gap / reset sequences.
module tb_shannon_whitaker_interp2x;

    localparam int INBITS  = 12;
    localparam int OUTBITS = 12;
    localparam int LAT     = 6;

    logic                     clk = 1'b0;
    logic                     rst_ni;
    logic [3:0][INBITS-1:0]   dat_i;
    logic                     valid_i;
    logic [7:0][OUTBITS-1:0]  dat_o;
    logic                     valid_o;

    shannon_whitaker_interp2x #(
        .INBITS  (INBITS),
        .OUTBITS (OUTBITS)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .dat_i   (dat_i),
        .valid_i (valid_i),
        .dat_o   (dat_o),
        .valid_o (valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    xval;
        int    exp_even;
        int    exp_odd;
    } dc_vec_t;

    int      checks   = 0;
    int      failures = 0;
    int      C [8]    = '{10342, -3216, 1672, -949, 526, -263, 105, 23};
    dc_vec_t dc_tab [6];

    int xs    [$];
    int exp_y [$];
    bit exp_v [$];
    int got_y [$];
    bit got_v [$];

    function automatic int xm(int i);
        if (i < 0 || i >= xs.size()) return 0;
        return xs[i];
    endfunction

    function automatic int clampo(longint v);
        longint hi;
        hi = (longint'(1) << (OUTBITS - 1)) - 1;
        if (v > hi) return int'(hi);
        if (v < -hi - 1) return int'(-hi - 1);
        return int'(v);
    endfunction

    function automatic int model_y(int idx);
        longint s, q, r;
        int n;
        if (idx % 2 == 0) return clampo(longint'(xm(idx / 2 - 8)));
        n = (idx - 1) / 2;
        s = 0;
        for (int k = 0; k < 8; k++)
            s += longint'(C[k]) * longint'(xm(n - 8 - k) + xm(n - 7 + k));
        q = s + 8192;
        if (q >= 0) r = q / 16384;
        else        r = -((-q + 16383) / 16384);
        return clampo(r);
    endfunction

    function automatic int lane(int j);
        return int'($signed(dat_o[j]));
    endfunction

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic chk_got(string name, int b, int j, int req);
        if (8 * b + j >= got_y.size()) begin
            checks++;
            failures++;
            $display("FAIL %s: beat %0d never observed, expected %0d", name, b, req);
        end else begin
            chk(name, got_y[8*b+j], req);
        end
    endtask

    task automatic chk_gotv(string name, int b, int req);
        if (b >= got_v.size()) begin
            checks++;
            failures++;
            $display("FAIL %s: beat %0d never observed, expected valid %0d", name, b, req);
        end else begin
            chk(name, int'(got_v[b]), req);
        end
    endtask

    // One clock: compare the beat due now, then drive the next beat.
    task automatic step(bit v, int s0, int s1, int s2, int s3);
        int s [4];
        int b;
        s = '{s0, s1, s2, s3};
        @(negedge clk);
        if (exp_v.size() >= LAT) begin
            bit ev;
            int ey, gy, bad, blane, bgot, bexp;
            ev  = exp_v.pop_front();
            bad = 0; blane = 0; bgot = 0; bexp = 0;
            for (int j = 0; j < 8; j++) begin
                ey = exp_y.pop_front();
                gy = lane(j);
                got_y.push_back(gy);
                if (gy != ey && bad == 0) begin
                    bad = 1; blane = j; bgot = gy; bexp = ey;
                end
            end
            got_v.push_back(valid_o);
            checks++;
            if (valid_o !== ev) begin
                failures++;
                $display("FAIL sb_valid beat %0d: got %0d, expected %0d",
                         got_v.size() - 1, valid_o, ev);
            end else if (bad != 0) begin
                failures++;
                $display("FAIL sb_data beat %0d lane %0d: got %0d, expected %0d",
                         got_v.size() - 1, blane, bgot, bexp);
            end
        end else begin
            checks++;
            if (valid_o !== 1'b0 || dat_o !== '0) begin
                failures++;
                $display("FAIL startup: got valid %0d dat %h, expected valid 0 dat 0",
                         valid_o, dat_o);
            end
        end
        valid_i = v;
        b = xs.size() / 4;
        for (int j = 0; j < 4; j++) begin
            dat_i[j] = INBITS'(s[j]);
            xs.push_back(v ? s[j] : 0);
        end
        for (int j = 0; j < 8; j++) exp_y.push_back(model_y(8 * b + j));
        exp_v.push_back(v);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_valid", int'(valid_o), 0);
        chk("async_rst_data", (dat_o == '0) ? 0 : 1, 0);
        xs.delete();
        exp_y.delete();
        exp_v.delete();
        got_y.delete();
        got_v.delete();
        valid_i = 1'b0;
        dat_i   = '0;
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int p [16];
        int d, k, b0;

        dc_tab[0] = '{"dc_1000",  1000,  1000,  1006};
        dc_tab[1] = '{"dc_2047",  2047,  2047,  2047};
        dc_tab[2] = '{"dc_m2048", -2048, -2048, -2048};
        dc_tab[3] = '{"dc_500",   500,   500,   503};
        dc_tab[4] = '{"dc_m1",    -1,    -1,    -1};
        dc_tab[5] = '{"dc_0",     0,     0,     0};

        rst_ni  = 1'b1;
        valid_i = 1'b0;
        dat_i   = '0;
        #1 rst_ni = 1'b0;
        #1;
        chk("reset_valid", int'(valid_o), 0);
        for (int j = 0; j < 8; j++) chk("reset_dat", lane(j), 0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;

        // Impulse x[0]=1000.
        step(1, 1000, 0, 0, 0);
        repeat (12) step(1, 0, 0, 0, 0);
        chk_got("imp_b1_l5", 1, 5, -196);
        chk_got("imp_b1_l7", 1, 7, 631);
        chk_got("imp_b2_l0", 2, 0, 1000);
        chk_got("imp_b2_l1", 2, 1, 631);

        // Steady-state DC table.
        pulse_reset();
        for (int r = 0; r < 6; r++) begin
            repeat (16) step(1, dc_tab[r].xval, dc_tab[r].xval, dc_tab[r].xval, dc_tab[r].xval);
            b0 = got_v.size() - 1;
            for (int j = 0; j < 8; j++)
                chk_got(dc_tab[r].name, b0, j, (j % 2 == 0) ? dc_tab[r].exp_even : dc_tab[r].exp_odd);
        end

        // Worst-case sign pattern aimed at y[31].
        pulse_reset();
        for (int j = 0; j < 16; j++) begin
            d = 15 - j;
            k = (d < 8) ? 7 - d : d - 8;
            p[j] = (C[k] > 0) ? -2048 : 2047;
        end
        for (int q = 0; q < 4; q++) step(1, p[4*q], p[4*q+1], p[4*q+2], p[4*q+3]);
        repeat (10) step(1, 0, 0, 0, 0);
        chk_got("worst_neg", 3, 7, -2048);

        // Valid gap on beats 10..12 of a DC stream.
        pulse_reset();
        for (int b = 0; b < 28; b++) step(!(b >= 10 && b <= 12), 1000, 1000, 1000, 1000);
        chk_gotv("gap_v9", 9, 1);
        chk_gotv("gap_v10", 10, 0);
        chk_gotv("gap_v11", 11, 0);
        chk_gotv("gap_v12", 12, 0);
        chk_gotv("gap_v13", 13, 1);
        chk_got("gap_b12_even", 12, 0, 0);
        chk_got("gap_b14_even", 14, 6, 0);
        chk_got("gap_b15_even", 15, 0, 1000);

        // Reset mid-stream, then restart from zero history.
        repeat (8) step(1, 1000, 1000, 1000, 1000);
        pulse_reset();
        repeat (12) step(1, 1000, 1000, 1000, 1000);
        chk_got("rst_ramp_b0", 0, 0, 0);
        chk_got("rst_ramp_b2", 2, 0, 1000);

        // Random stream.
        pulse_reset();
        repeat (3000)
            step(($urandom % 10) != 0,
                 int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048,
                 int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048);
        repeat (LAT) step(0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shannon_whitaker_interp2x.md
SHANNON_WHITAKER_INTERP2X -- requirements
Module: shannon_whitaker_interp2x

Interface
REQ-001 SHALL have parameter INBITS, default 12, input sample width, signed two's complement.
REQ-002 SHALL have parameter OUTBITS, default 12, output sample width, signed two's complement.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port dat_i  input  [3:0][INBITS-1:0]  4 samples/clock; dat_i[k] = x[4b+k] for input beat b.
REQ-006 SHALL have port valid_i  input  1  qualifies dat_i for the current beat.
REQ-007 SHALL have port dat_o  output  [7:0][OUTBITS-1:0]  8 samples/clock; dat_o[k] = y[8b+k].
REQ-008 SHALL have port valid_o  output  1  qualifies dat_o.

Function
REQ-009 SHALL implement a 2x half-band interpolator: even outputs y[2n] = x[n-8] exactly (no scaling, no rounding).
REQ-010 SHALL compute odd outputs y[2n+1] = sum over k=0..7 of C[k]*(x[n-8-k] + x[n-7+k]), with C = {10342, -3216, 1672, -949, 526, -263, 105, 23} (k=0 nearest tap).
REQ-011 SHALL treat coefficients as Q14: odd result = floor((sum + 2^13) / 2^14), i.e. round half up.
REQ-012 SHALL saturate each odd result to [-2^(OUTBITS-1), 2^(OUTBITS-1)-1]; even results saturate identically when OUTBITS < INBITS and sign-extend when OUTBITS > INBITS.
REQ-013 SHALL carry full precision internally (no intermediate truncation before REQ-011).
REQ-014 SHALL present output beat b (y[8b..8b+7]) on dat_o exactly L=6 clocks after input beat b is on dat_i; the latency is fixed and independent of valid_i.
REQ-015 SHALL run free: history advances every clock and there are no stalls or backpressure.
REQ-016 SHALL substitute zero for all four samples of any beat with valid_i=0 before they enter the history.
REQ-017 SHALL generate valid_o as valid_i delayed by exactly L clocks.
REQ-018 SHALL not gate or zero dat_o when valid_o=0; the computed value is still driven.
REQ-019 SHALL use only registered preadd/multiply/cascade paths with no combinational path from inputs to outputs.

Reset
REQ-020 SHALL, on rst_ni low, asynchronously clear all history, pipeline and output registers: dat_o = 0, valid_o = 0.
REQ-021 SHALL, after rst_ni deasserts, behave as if all prior x[] were zero; the first L clocks produce valid_o=0.
REQ-022 SHALL, on reset asserted mid-stream, discard all in-flight beats with no partial outputs after release.

Structure
REQ-023 SHALL take C[], the Q14 shift (14), the rounding constant and L from package shannon_whitaker_pkg, which is shared with the lowpass filter.
REQ-024 SHALL build the odd-phase MAC from the existing fourtap_systolic_preadd sub-module (two cascaded instances per odd lane, CASCADE="TRUE" on the second); no new sub-module.
REQ-025 SHALL realise even lanes as a plain delay line matched to L.

Verification
REQ-026 Impulse test: x[0]=1000 at beat 0, valid_i=1 throughout, else 0 -> cycle 7: dat_o[5]=-196, dat_o[7]=631; cycle 8: dat_o[0]=1000, dat_o[1]=631; matching odd taps (y[2n+1] per REQ-010) elsewhere.
REQ-027 DC test: x=1000 constant -> steady state even lanes 1000, odd lanes 1006.
REQ-028 Saturation test: x=2047 constant -> odd lanes 2047 (unsaturated 2059), even lanes 2047; a worst-case sign pattern (x = -2048*sign(C)) -> odd lane -2048.
REQ-029 Valid gating test: DC 1000 with valid_i low for beats 10..12 -> valid_o low at cycles 16..18; outputs reflect zeros injected at x[40..51].
REQ-030 Reset test: rst_ni pulsed low mid-DC stream -> dat_o=0 and valid_o=0 immediately (asynchronously); after release, outputs ramp as from zero history and valid_o stays low for 6 clocks.
REQ-031 Random test: 10^5 random valid beats against a bit-exact reference model implementing REQ-009..REQ-017 -> zero mismatches.
